// File: rtl/uart_tx_fifo_drain.sv
// Drains a TX FIFO (RD_LATENCY read pipeline) into UART frames: start, 7/8 data LSB first, optional parity, stop.
// Next START comes RD_LATENCY+1 clocks after the fetch decision; the FIFO is only read when non-empty.
module uart_tx_fifo_drain #(
    parameter int OVERSAMPLE = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data_out,
    output logic       fifo_read_n,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    output logic       tx,
    output logic       tx_busy
);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [3:0]    tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit8_q, bit8_d;
    logic          par_en_q, par_en_d;
    logic          par_q, par_d;
    logic          bit_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            tick_q   <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            shift_q  <= '0;
            bit8_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            shift_q  <= shift_d;
            bit8_q   <= bit8_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = 1'b1;
        tick_d   = tick_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        shift_d  = shift_q;
        bit8_d   = bit8_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        bit_end  = 1'b0;

        // Oversample ticks only count while a bit is on the line.
        if ((state_q inside {START, DATA, PARITY, STOP}) && baud_en) begin
            if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                bit_end = 1'b1;
            end else begin
                tick_d = tick_q + 4'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                wait_d  = '0;
                state_d = fifo_empty ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    // Parity is resolved here so the whole frame format is frozen at capture.
                    shift_d  = fifo_data_out;
                    bit8_d   = bit8;
                    par_en_d = parity_en;
                    par_d    = (^(fifo_data_out & (bit8 ? 8'hFF : 8'h7F))) ^ odd_n_even;
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = START;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == (bit8_q ? 3'd7 : 3'd6)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = fifo_empty ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase

        // tx is a flop whose next value follows the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx          = tx_q;
    assign tx_busy     = (state_q != IDLE);
    assign fifo_read_n = !((state_q == FETCH) && !fifo_empty);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a two-stage read-latency FIFO model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;
    localparam int OVS = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       baud_en = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_read_n;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       tx;
    logic       tx_busy;

    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;
    logic [7:0] fq[$];
    logic       pipe_vld = 1'b0;
    logic [7:0] pipe_dat = 8'h00;
    int         rd_cnt = 0;
    int         bad_rd = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         baud_period = 1;
    int         bcnt = 0;
    int         bit_len[12];

    always #5 clock = ~clock;

    uart_tx_fifo_drain #(.OVERSAMPLE(16), .RD_LATENCY(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .baud_en       (baud_en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read_n   (fifo_read_n),
        .bit8          (bit8),
        .parity_en     (parity_en),
        .odd_n_even    (odd_n_even),
        .tx            (tx),
        .tx_busy       (tx_busy)
    );

    // Read data is valid only on the edge RD_LATENCY after the read strobe.
    always @(posedge clock) begin : fifo_model
        logic [7:0] popped;
        popped = 8'hEE;
        if (push_vld) fq.push_back(push_dat);
        if (!fifo_read_n) begin
            rd_cnt++;
            if (fifo_empty) bad_rd++;
            if (fq.size() != 0) popped = fq.pop_front();
        end
        fifo_data_out <= pipe_vld ? pipe_dat : 8'hEE;
        pipe_vld      <= !fifo_read_n;
        pipe_dat      <= popped;
        fifo_empty    <= (fq.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        bcnt    = (bcnt + 1) % baud_period;
        baud_en = (bcnt == 0);
    endtask

    task automatic push(input logic [7:0] b);
        push_dat = b;
        push_vld = 1'b1;
        @(posedge clock);
        #1;
        push_vld = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_busy), 32'd1);
    endtask

    // exp_bits[k] is the k-th bit on the line (k=0 is the start bit).
    // A bit ends on its OVS-th baud_en tick; gap counts idle-high clocks before START.
    task automatic run_frame(input string tag, input logic [11:0] exp_bits, input int nbits,
                             input int tog_bit, output int gap);
        int   ticks;
        int   cyc;
        logic badv;
        gap = 0;
        while (tx !== 1'b0 && gap < 200) begin
            tick();
            gap++;
        end
        check({tag, "_start"}, 32'(tx), 32'd0);
        for (int k = 0; k < nbits; k++) begin
            ticks = 0;
            cyc   = 0;
            badv  = exp_bits[k];
            if (k == tog_bit) parity_en = ~parity_en;
            while (ticks < OVS && cyc < 200) begin
                if (tx !== exp_bits[k]) badv = tx;
                if (baud_en) ticks++;
                cyc++;
                tick();
            end
            bit_len[k] = cyc;
            check($sformatf("%s_bit%0d", tag, k), {30'd0, (ticks < OVS), badv},
                  {30'd0, 1'b0, exp_bits[k]});
        end
    endtask

    initial begin
        int g;
        int rd0;
        int ok;
        int bad;

        reset_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_read_n", 32'(fifo_read_n), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) tick();
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(tx_busy), 32'd0);

        // 8N1 0x55, baud_en tied high
        rd0 = rd_cnt;
        push(8'h55);
        wait_busy("t1_busy");
        check("t1_read_n", 32'(fifo_read_n), 32'd0);
        run_frame("t1", 12'b001010101010, 10, -1, g);
        check("t1_start_clk", 32'(g), 32'd3);
        ok = 0;
        for (int k = 0; k < 10; k++) if (bit_len[k] == 16) ok++;
        check("t1_bitlen", 32'(ok), 32'd10);
        check("t1_busy_end", 32'(tx_busy), 32'd0);
        check("t1_reads", 32'(rd_cnt - rd0), 32'd1);

        // 7E1 0xC3: bit7 must not be sent, parity 1
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        push(8'hC3);
        wait_busy("t2_busy");
        run_frame("t2", 12'b001110000110, 10, -1, g);
        check("t2_start_clk", 32'(g), 32'd3);
        check("t2_busy_end", 32'(tx_busy), 32'd0);

        // 8O1 0x00 with baud_en every 4th clock
        bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1;
        baud_period = 4;
        push(8'h00);
        wait_busy("t3_busy");
        run_frame("t3", 12'b011000000000, 11, -1, g);
        ok = 0;
        for (int k = 1; k < 11; k++) if (bit_len[k] == 64) ok++;
        check("t3_bitlen64", 32'(ok), 32'd10);
        check("t3_busy_end", 32'(tx_busy), 32'd0);
        baud_period = 1;

        // three bytes back to back, 8N1
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
        rd0 = rd_cnt;
        push(8'hA1);
        push(8'h0F);
        push(8'h7E);
        run_frame("t4a", 12'b001101000010, 10, -1, g);
        run_frame("t4b", 12'b001000011110, 10, -1, g);
        check("t4b_gap", 32'(g), 32'd3);
        run_frame("t4c", 12'b001011111100, 10, -1, g);
        check("t4c_gap", 32'(g), 32'd3);
        check("t4_busy_end", 32'(tx_busy), 32'd0);
        check("t4_reads", 32'(rd_cnt - rd0), 32'd3);
        check("t4_read_empty", 32'(bad_rd), 32'd0);

        // parity_en flipped during DATA of frame 1 only affects frame 2
        parity_en = 1'b0;
        push(8'h55);
        push(8'h55);
        run_frame("t5a", 12'b001010101010, 10, 3, g);
        run_frame("t5b", 12'b010010101010, 11, -1, g);
        check("t5b_gap", 32'(g), 32'd3);
        check("t5_busy_end", 32'(tx_busy), 32'd0);

        // reset in the 4th data bit aborts the frame at once
        parity_en = 1'b0;
        rd0 = rd_cnt;
        push(8'h55);
        wait_busy("t6_busy");
        g = 0;
        while (tx !== 1'b0 && g < 50) begin
            tick();
            g++;
        end
        check("t6_start", 32'(tx), 32'd0);
        repeat (72) tick();
        check("t6_pre_rst_tx", 32'(tx), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_busy", 32'(tx_busy), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("t6_quiet", 32'(bad), 32'd0);
        check("t6_reads", 32'(rd_cnt - rd0), 32'd1);
        check("read_while_empty", 32'(bad_rd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
